// File: rtl/ghash_pkg.sv
// Shared constants, FSM state type and parameter helpers for the serial GHASH multiplier.
package ghash_pkg;

  // GCM reduction constant, [0:127] bit order (bit 0 = coefficient x^0).
  localparam logic [0:127] R_POLY_DEF = {8'hE1, 120'd0};

  typedef enum logic {IDLE, RUN} state_e;

  function automatic int ncyc(input int digit);
    return 128 / digit;
  endfunction

  function automatic bit digit_legal(input int digit);
    return digit inside {1, 2, 4, 8, 16, 32, 64, 128};
  endfunction

endpackage

// File: rtl/gf128_digit_step.sv
// DIGIT unrolled shift-and-add steps of the GCM bit-serial multiply (combinational).
module gf128_digit_step
  import ghash_pkg::*;
#(
  parameter int           DIGIT  = 8,
  parameter logic [0:127] R_POLY = R_POLY_DEF
) (
  input  logic [0:127]     z_i,
  input  logic [0:127]     v_i,
  input  logic [0:DIGIT-1] a_i,
  output logic [0:127]     z_o,
  output logic [0:127]     v_o
);

  logic [0:127] z, v;

  always_comb begin
    z = z_i;
    v = v_i;
    for (int i = 0; i < DIGIT; i++) begin
      if (a_i[i]) z = z ^ v;
      // >> moves toward higher index; bit 127 is the x^127 coefficient
      v = v[127] ? ((v >> 1) ^ R_POLY) : (v >> 1);
    end
  end

  assign z_o = z;
  assign v_o = v;

endmodule

// File: rtl/ghash_mul_serial.sv
// Digit-serial GF(2^128) multiplier with optional GHASH accumulate: Y = (Y ^ X)*H.
module ghash_mul_serial
  import ghash_pkg::*;
#(
  parameter int           DIGIT  = 8,
  parameter logic [0:127] R_POLY = R_POLY_DEF
) (
  input  logic         iClk,
  input  logic         iRstn,
  input  logic         iValid,
  output logic         oReady,
  input  logic         iMode,
  input  logic         iClear,
  input  logic [0:127] iData,
  input  logic [0:127] iHashkey,
  output logic [0:127] oResult,
  output logic         oValid,
  output logic         oBusy
);

  localparam int NCYC = ncyc(DIGIT);
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

  if (!digit_legal(DIGIT)) begin : g_bad_digit
    $error("ghash_mul_serial: DIGIT must be a power of two in 1..128");
  end

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [0:127]  a_q, z_q, v_q, y_q, res_q;
  logic          mode_q, ovld_q;
  logic [0:127]  z_nx, v_nx, y_eff;
  logic          last;

  gf128_digit_step #(.DIGIT(DIGIT), .R_POLY(R_POLY)) u_step (
    .z_i (z_q),
    .v_i (v_q),
    .a_i (a_q[0:DIGIT-1]),
    .z_o (z_nx),
    .v_o (v_nx)
  );

  assign y_eff = iClear ? '0 : y_q;
  assign last  = (cnt_q == CW'(NCYC - 1));

  // A is shifted toward index 0 so the step always consumes its leading DIGIT bits.
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      z_q     <= '0;
      v_q     <= '0;
      y_q     <= '0;
      res_q   <= '0;
      mode_q  <= 1'b0;
      ovld_q  <= 1'b0;
    end else begin
      ovld_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (iClear) y_q <= '0;
          if (iValid) begin
            a_q     <= iMode ? (iData ^ y_eff) : iData;
            v_q     <= iHashkey;
            z_q     <= '0;
            cnt_q   <= '0;
            mode_q  <= iMode;
            state_q <= RUN;
          end
        end
        RUN: begin
          z_q   <= z_nx;
          v_q   <= v_nx;
          a_q   <= a_q << DIGIT;
          cnt_q <= cnt_q + CW'(1);
          if (last) begin
            res_q   <= z_nx;
            ovld_q  <= 1'b1;
            if (mode_q) y_q <= z_nx;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign oReady  = (state_q == IDLE);
  assign oBusy   = (state_q == RUN);
  assign oValid  = ovld_q;
  assign oResult = res_q;

endmodule

// File: tb/tb_ghash_mul_serial.sv
// Directed-vector bench for ghash_mul_serial (DIGIT=8 main instance plus a DIGIT sweep).
module tb_ghash_mul_serial;

  localparam logic [0:127] X1  = 128'h0388DACE60B6A392F328C2B971B2FE78;
  localparam logic [0:127] H1  = 128'h66E94BD4EF8A2C3B884CFA59CA342B2E;
  localparam logic [0:127] P1  = 128'h5E2EC746917062882C85B0685353DEB7;
  localparam logic [0:127] H2  = 128'h73A23D80121DE2D5A850253FCF43120E;
  localparam logic [0:127] A1  = 128'hD609B1F056637A0D46DF998D88E52E00;
  localparam logic [0:127] A2  = 128'hB2C2846512153524C0895E8100000000;
  localparam logic [0:127] A3  = 128'h701AFA1CC039C0D765128A665DAB6924;
  localparam logic [0:127] Y1  = 128'h9CABBD91899C1413AA7AD629C1DF12CD;
  localparam logic [0:127] Y2  = 128'hB99ABF6BDBD18B8E148F8030F0686F28;
  localparam logic [0:127] Y3  = 128'h8B5BD74B9A65A459150392C3872BCE7F;
  localparam logic [0:127] ONE = 128'h80000000000000000000000000000000;

  logic         iClk = 1'b0, iRstn = 1'b1;
  logic         iValid = 1'b0, iMode = 1'b0, iClear = 1'b0;
  logic [0:127] iData = '0, iHashkey = '0;
  logic         oReady, oValid, oBusy;
  logic [0:127] oResult;

  logic         sw_valid [4];
  logic         sw_ready [4], sw_ovld [4], sw_busy [4];
  logic [0:127] sw_res   [4];
  int           sw_lat_exp [4] = '{128, 32, 4, 1};

  int n_chk = 0, n_err = 0;

  always #5 iClk = ~iClk;

  ghash_mul_serial #(.DIGIT(8)) u_dut (
    .iClk(iClk), .iRstn(iRstn), .iValid(iValid), .oReady(oReady),
    .iMode(iMode), .iClear(iClear), .iData(iData), .iHashkey(iHashkey),
    .oResult(oResult), .oValid(oValid), .oBusy(oBusy)
  );

  for (genvar g = 0; g < 4; g++) begin : g_sw
    localparam int D = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 32 : 128;
    ghash_mul_serial #(.DIGIT(D)) u_sw (
      .iClk(iClk), .iRstn(iRstn), .iValid(sw_valid[g]), .oReady(sw_ready[g]),
      .iMode(iMode), .iClear(iClear), .iData(iData), .iHashkey(iHashkey),
      .oResult(sw_res[g]), .oValid(sw_ovld[g]), .oBusy(sw_busy[g])
    );
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge iClk);
    #1;
  endtask

  function automatic logic [0:127] junk();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // One accept on the main instance; lat = edges from accept to oValid.
  task automatic op(input logic m, input logic c, input logic [0:127] x, input logic [0:127] h,
                    output logic [0:127] res, output int lat);
    iValid = 1'b1; iMode = m; iClear = c; iData = x; iHashkey = h;
    tick;
    iValid = 1'b0; iClear = 1'b0; iData = junk(); iHashkey = junk();
    lat = 0;
    while (!oValid && lat < 300) begin tick; lat++; end
    res = oResult;
  endtask

  task automatic sw_op(input int i, input logic [0:127] x, input logic [0:127] h,
                       output logic [0:127] res, output int lat);
    sw_valid[i] = 1'b1; iMode = 1'b0; iClear = 1'b0; iData = x; iHashkey = h;
    tick;
    sw_valid[i] = 1'b0; iData = junk(); iHashkey = junk();
    lat = 0;
    while (!sw_ovld[i] && lat < 300) begin tick; lat++; end
    res = sw_res[i];
  endtask

  task automatic acc_seq(input string tag, input logic first_clr);
    logic [0:127] r;
    int lat;
    op(1'b1, first_clr, A1, H2, r, lat); chk({tag, "_y1"}, r, Y1);
    op(1'b1, 1'b0,      A2, H2, r, lat); chk({tag, "_y2"}, r, Y2);
    op(1'b1, 1'b0,      A3, H2, r, lat); chk({tag, "_y3"}, r, Y3);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [0:127] r;
    int lat, acc, last_acc, bad, pulses;
    foreach (sw_valid[i]) sw_valid[i] = 1'b0;

    #2 iRstn = 1'b0;
    #1;
    chk("rst_ready",  oReady,  1'b1);
    chk("rst_busy",   oBusy,   1'b0);
    chk("rst_valid",  oValid,  1'b0);
    chk("rst_result", oResult, '0);
    tick; tick;
    iRstn = 1'b1;
    tick;

    // basic product and latency
    op(1'b0, 1'b0, X1, H1, r, lat);
    chk("t1_result", r, P1);
    chk("t1_lat", lat, 16);
    chk("t1_ready_in_valid", oReady, 1'b1);
    tick;
    chk("t1_valid_pulse", oValid, 1'b0);
    chk("t1_result_held", oResult, P1);

    acc_seq("t2", 1'b1);

    // iClear while running must not touch Y; H=1 makes the product equal Y^X
    tick;
    iValid = 1'b1; iMode = 1'b1; iClear = 1'b0; iData = '0; iHashkey = ONE;
    tick;
    iValid = 1'b0; iClear = 1'b1; iData = junk();
    lat = 0;
    while (!oValid && lat < 300) begin tick; lat++; end
    iClear = 1'b0;
    chk("t6_clr_run", oResult, Y3);
    op(1'b1, 1'b0, '0, ONE, r, lat);
    chk("t6_y_survives", r, Y3);
    tick;
    iClear = 1'b1; tick; iClear = 1'b0;
    acc_seq("t6_reseq", 1'b0);

    // identity / zero operands
    op(1'b0, 1'b0, ONE, H2, r, lat);  chk("t3_ident", r, H2);
    op(1'b0, 1'b0, '0,  H1, r, lat);  chk("t3_zero_x", r, '0);
    op(1'b0, 1'b0, X1,  '0, r, lat);  chk("t3_zero_h", r, '0);
    chk("t3_zero_h_lat", lat, 16);
    for (int i = 0; i < 4; i++) begin
      sw_op(i, ONE, H1, r, lat);
      chk($sformatf("t3_sw%0d_res", i), r, H1);
      chk($sformatf("t3_sw%0d_lat", i), lat, sw_lat_exp[i]);
    end
    for (int i = 0; i < 4; i++) begin
      sw_op(i, X1, H1, r, lat);
      chk($sformatf("t3_sw%0d_prod", i), r, P1);
    end

    // iValid held high: accepts only in IDLE, NCYC busy cycles then one IDLE cycle
    tick;
    iValid = 1'b1; iMode = 1'b0; iClear = 1'b0; iHashkey = H1;
    acc = 0; last_acc = -1; bad = 0;
    for (int c = 0; c <= 60; c++) begin
      iData = oReady ? X1 : junk();
      if (oBusy && oReady) bad++;
      if (oValid) chk("t4_result", oResult, P1);
      if (oReady) begin
        if (last_acc >= 0) chk("t4_gap", c - last_acc, 17);
        last_acc = c;
        acc++;
      end
      tick;
    end
    iValid = 1'b0;
    lat = 0;
    while (oBusy && lat < 300) begin tick; lat++; end
    chk("t4_accepts", acc, 4);
    chk("t4_ready_low_busy", bad, 0);
    chk("t4_last_result", oResult, P1);

    // async reset mid-run aborts and clears Y
    tick;
    iValid = 1'b1; iMode = 1'b1; iData = X1; iHashkey = H1;
    tick;
    iValid = 1'b0;
    repeat (4) tick;
    iRstn = 1'b0;
    #1;
    chk("t5_valid", oValid, 1'b0);
    chk("t5_result", oResult, '0);
    chk("t5_busy", oBusy, 1'b0);
    chk("t5_ready", oReady, 1'b1);
    tick; tick;
    iRstn = 1'b1;
    pulses = 0;
    repeat (20) begin tick; if (oValid) pulses++; end
    chk("t5_no_pulse", pulses, 0);
    op(1'b1, 1'b0, X1, H1, r, lat);
    chk("t5_y_zero", r, P1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
